debug_mem_dump_ctrl: RTL and testbench
======================================

# debug_mem_dump_ctrl

Sequencer that dumps the full contents of the data memory to the debug UART transmitter on command. It sits between the debug unit and the data memory's debug read port. It walks every word address, captures each word, and serializes it MSB-byte-first into a byte-wide valid/ready stream. While dumping it holds off pipeline stepping so memory contents cannot change mid-dump.

## Interface
Parameters:
- `BITS_SIZE`, 32, data/address width of the memory; must be a multiple of 8
- `SIZE_MEM_DATA`, 16, number of memory words to dump (addresses 0..SIZE_MEM_DATA-1)

Ports:
- `i_clk`  in  1  clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-low reset (low = reset)
- `i_start`  in  1  dump request, level-sampled in IDLE only
- `i_mem_data`  in  BITS_SIZE  word from memory debug read port (combinational from `o_mem_address`)
- `i_tx_ready`  in  1  UART transmitter can accept a byte this cycle
- `o_mem_address`  out  BITS_SIZE  memory debug read address
- `o_tx_data`  out  8  byte to transmit
- `o_tx_valid`  out  1  `o_tx_data` valid
- `o_busy`  out  1  dump in progress
- `o_step_hold`  out  1  inhibit pipeline step; equals `o_busy`
- `o_done`  out  1  one-cycle pulse at end of dump

## Operation
- States: IDLE, ADDR, LATCH, SEND, DONE (plus HDR0, HDR1 under the macro).
- IDLE: outputs low, address 0. If `i_start`=1, go to ADDR (or HDR0 if the macro is enabled).
- ADDR: drive `o_mem_address`=addr, allowing one cycle for memory read to settle. Go to LATCH.
- LATCH: shift register <= `i_mem_data`; byte counter <= BITS_SIZE/8-1. Go to SEND.
- SEND: `o_tx_valid`=1, `o_tx_data`=shift_reg[BITS_SIZE-1 -: 8].
  - On `o_tx_valid & i_tx_ready`, shift left by 8 and decrement the byte counter.
  - On the last byte, if addr==SIZE_MEM_DATA-1, go to DONE. Otherwise addr+1 and go to ADDR.
- DONE: `o_done`=1 for one cycle, address reset to 0. Go to IDLE.
- Handshake rules:
  - Once asserted, `o_tx_valid` stays high and `o_tx_data` stays stable until accepted.
  - `i_tx_ready` may toggle freely.
  - Acceptance occurs only on a cycle where both are high.
- `i_start` is ignored outside IDLE; a held `i_start` after DONE starts a new dump from the IDLE cycle.
- Address counter is clog2(SIZE_MEM_DATA) bits wide and zero-extended onto `o_mem_address`. It never wraps past SIZE_MEM_DATA-1.
- Reset at any point: next cycle state=IDLE, and all of the following are 0: `o_mem_address`, `o_tx_data`, `o_tx_valid`, `o_busy`, `o_step_hold`, `o_done`, plus the shift register and counters. A partially sent word is abandoned.

## Timing
- All outputs are registered-state decodes; no combinational path from `i_tx_ready` to `o_tx_valid`.
- `i_start` high in IDLE at cycle t → `o_busy` high from t+1.
- With `i_tx_ready` constantly high, each word takes 2 + BITS_SIZE/8 cycles: 6 cycles at 32 bits.
- Defaults, `i_tx_ready` constantly high, no macro: 96 busy cycles for the words, then `o_done` high at t+97 and `o_busy` low at t+98.
- Each low-`i_tx_ready` cycle during SEND adds exactly one cycle.

## Configuration
- `DUMP_HEADER_EN` defined:
  - Before the first word, send header byte 0xA5 (HDR0), then SIZE_MEM_DATA[7:0] (HDR1), each with the same valid/ready rules.
  - Adds 2 cycles when ready is constantly high; `o_done` lands at t+99.
- `DUMP_HEADER_EN` undefined: HDR states absent, and the stream is words only.

## Test plan
- Memory preloaded with word[i]=i, ready constantly high, start pulse at t → 64 bytes in the order 00 00 00 00, 00 00 00 01 … 00 00 00 0F, `o_done` at t+97, `o_step_hold` high for t+1..t+97.
- Same dump with `i_tx_ready` low for 3 cycles during byte 2 of word 5 → byte 00 held stable with valid high, stream order unchanged, `o_done` at t+100.
- Reset (`i_reset`=0) driven during word 7 SEND → next cycle all outputs 0, state IDLE. A new start then dumps from address 0.
- `i_start` held high continuously → second dump begins in the IDLE cycle after DONE, and no start is accepted while busy.
- Word[3]=0xDEADBEEF → bytes DE AD BE EF, in that order.
- With `DUMP_HEADER_EN` defined → first bytes A5 10, then the data stream, `o_done` at t+99.

Source files
------------

// File: rtl/debug_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_mem_dump_ctrl
// Brief    : Walks the data memory and streams every word MSB-byte-first to
//            the debug UART; optional 0xA5/size header under DUMP_HEADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module debug_mem_dump_ctrl #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BITS_SIZE-1:0] i_mem_data,
  input  logic                 i_tx_ready,
  output logic [BITS_SIZE-1:0] o_mem_address,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_step_hold,
  output logic                 o_done
);

  localparam int BYTES = BITS_SIZE / 8;
  localparam int AW    = (SIZE_MEM_DATA > 1) ? $clog2(SIZE_MEM_DATA) : 1;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE_MEM_DATA - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BYTES - 1);
`ifdef DUMP_HEADER_EN
  localparam logic [7:0]    HDR0_BYTE = 8'hA5;
  localparam logic [7:0]    HDR1_BYTE = 8'(SIZE_MEM_DATA);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_SEND,
    S_DONE
`ifdef DUMP_HEADER_EN
    ,
    S_HDR0,
    S_HDR1
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q,  addr_d;
  logic [BITS_SIZE-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q,   cnt_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    o_tx_valid    = 1'b0;
    o_tx_data     = shift_q[BITS_SIZE-1 -: 8];
    o_done        = 1'b0;
    o_busy        = (state_q != S_IDLE);
    o_step_hold   = (state_q != S_IDLE);
    o_mem_address = BITS_SIZE'(addr_q);

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (i_start) begin
`ifdef DUMP_HEADER_EN
          state_d = S_HDR0;
`else
          state_d = S_ADDR;
`endif
        end
      end
`ifdef DUMP_HEADER_EN
      S_HDR0: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HDR0_BYTE;
        if (i_tx_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HDR1_BYTE;
        if (i_tx_ready) state_d = S_ADDR;
      end
`endif
      // The read port is combinational from the address; one settle cycle.
      S_ADDR: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_d = i_mem_data;
        cnt_d   = LAST_CNT;
        state_d = S_SEND;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            cnt_d = '0;
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_ADDR;
            end
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_mem_dump_ctrl
// Brief    : Randomised self-checking bench with a byte-queue/cycle-budget model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_mem_dump_ctrl;

  localparam int BITS  = 32;
  localparam int SIZE  = 16;
  localparam int BYTES = BITS / 8;
`ifdef DUMP_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int DONE_OFS = 1 + HDR + SIZE * (2 + BYTES);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            ready;
  logic [BITS-1:0] mem_data;
  logic [BITS-1:0] addr;
  logic [7:0]      tx_data;
  logic            valid, busy, hold, done;

  logic [BITS-1:0] mem [SIZE];

  debug_mem_dump_ctrl #(.BITS_SIZE(BITS), .SIZE_MEM_DATA(SIZE)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_mem_data   (mem_data),
    .i_tx_ready   (ready),
    .o_mem_address(addr),
    .o_tx_data    (tx_data),
    .o_tx_valid   (valid),
    .o_busy       (busy),
    .o_step_hold  (hold),
    .o_done       (done)
  );

  assign mem_data = (addr < BITS'(SIZE)) ? mem[addr[3:0]] : '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a dump is a fixed byte list plus a cycle budget that
  // grows by one for every presented-but-not-accepted byte.
  bit         m_active = 1'b0;
  int         m_start, m_end;
  logic [7:0] exp_q [$];
  logic [7:0] rx    [$];
  int         starts[$];
  int         ddone [$];
  int         hold_cnt = 0;
  bit         stall_pend = 1'b0;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    bit was_active;
    bit exp_busy;
    was_active = m_active;
    exp_busy   = m_active && (cyc > m_start) && (cyc <= m_end);

    check("step_hold_eq_busy", hold, busy);
    check("busy", busy, exp_busy);
    check("done", done, m_active && (cyc == m_end));
    if (!exp_busy) begin
      check("idle_valid", valid, 1'b0);
      check("idle_addr", addr, '0);
      check("idle_data", tx_data, 8'h00);
    end
    if (stall_pend) begin
      check("held_valid", valid, 1'b1);
      check("held_data", tx_data, prev_data);
    end
    if (done) ddone.push_back(cyc);
    if (hold) hold_cnt++;

    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", 1'b1, 1'b0);
      end else begin
        check("stream_byte", tx_data, exp_q.pop_front());
      end
      rx.push_back(tx_data);
    end
    stall_pend = rst_n && valid && !ready;
    prev_data  = tx_data;
    if (rst_n && exp_busy && valid && !ready) m_end++;

    if (was_active && cyc == m_end) begin
      check("bytes_left_at_done", exp_q.size(), 0);
      m_active = 1'b0;
    end

    if (!was_active && rst_n && start) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_end    = cyc + DONE_OFS;
      hold_cnt = 0;
      starts.push_back(cyc);
      rx.delete();
      exp_q.delete();
`ifdef DUMP_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(SIZE));
`endif
      for (int w = 0; w < SIZE; w++)
        for (int b = BYTES - 1; b >= 0; b--)
          exp_q.push_back(mem[w][8*b +: 8]);
    end

    if (!rst_n) begin
      m_active   = 1'b0;
      stall_pend = 1'b0;
      exp_q.delete();
    end
  end

  bit rnd_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (ddone.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (ddone.size() < n) check(name, 1'b0, 1'b1);
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (rx.size() < n) check(name, rx.size(), n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < SIZE; i++) mem[i] = BITS'(i);
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_addr", addr, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Plain dump of word[i] = i
    nd = ddone.size();
    pulse_start();
    wait_dones(nd + 1, 300, "timeout_dump1");
    check("dump1_done_ofs", ddone[nd] - starts[starts.size()-1], 97 + HDR);
    check("dump1_hold_cycles", hold_cnt, 97 + HDR);
    check("dump1_nbytes", rx.size(), 64 + HDR);
    check("dump1_b3", rx[HDR+3], 8'h00);
    check("dump1_b7", rx[HDR+7], 8'h01);
    check("dump1_b63", rx[HDR+63], 8'h0F);
`ifdef DUMP_HEADER_EN
    check("hdr0", rx[0], 8'hA5);
    check("hdr1", rx[1], 8'h10);
`endif
    repeat (3) tick();

    // Three-cycle stall on the second byte of word 5
    nd = ddone.size();
    pulse_start();
    wait_rx(HDR + 21, 300, "timeout_stall_wait");
    ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    wait_dones(nd + 1, 300, "timeout_dump2");
    check("stall_done_ofs", ddone[nd] - starts[starts.size()-1], 100 + HDR);
    check("stall_byte", rx[HDR+21], 8'h00);
    check("stall_nbytes", rx.size(), 64 + HDR);
    repeat (2) tick();

    // Reset in the middle of word 7
    pulse_start();
    wait_rx(HDR + 29, 300, "timeout_reset_wait");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_busy", busy, 1'b0);
    check("reset_valid", valid, 1'b0);
    check("reset_addr", addr, '0);
    check("reset_data", tx_data, 8'h00);
    tick();
    nd = ddone.size();
    pulse_start();
    wait_dones(nd + 1, 300, "timeout_after_reset");
    check("after_reset_nbytes", rx.size(), 64 + HDR);
    repeat (2) tick();

    // Byte order within a word
    mem[3] = 32'hDEADBEEF;
    nd = ddone.size();
    pulse_start();
    wait_dones(nd + 1, 300, "timeout_deadbeef");
    check("beef_b0", rx[HDR+12], 8'hDE);
    check("beef_b1", rx[HDR+13], 8'hAD);
    check("beef_b2", rx[HDR+14], 8'hBE);
    check("beef_b3", rx[HDR+15], 8'hEF);
    repeat (2) tick();

    // Start held high: back-to-back dumps
    nd = ddone.size();
    start = 1'b1;
    wait_dones(nd + 2, 600, "timeout_held_start");
    start = 1'b0;
    check("restart_gap", starts[starts.size()-1] - ddone[nd], 1);
    for (int k = 0; k < 300 && m_active; k++) tick();
    repeat (2) tick();

    // Randomised memory and ready
    rnd_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < SIZE; i++) mem[i] = $urandom();
      repeat ($urandom_range(1, 5)) tick();
      nd = ddone.size();
      pulse_start();
      wait_dones(nd + 1, 1000, "timeout_random");
      check("random_nbytes", rx.size(), 64 + HDR);
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
